// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit. One shift-add or restoring-divide
// step runs per cycle, followed by a sign-correction cycle.
module muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [TAGW-1:0]  tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             o,
    output logic [TAGW-1:0]  tag_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic              neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic              div0_q, div0_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]  result_q, result_d, remainder_q, remainder_d;
    logic              o_q, o_d;
    logic [TAGW-1:0]   tag_out_q, tag_out_d;

    function automatic logic [WIDTH-1:0] twos_w(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] twos_2w(input logic [2*WIDTH-1:0] v);
        return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic              s1_s, s2_s;
    logic [WIDTH-1:0]  mag1_s, mag2_s;
    logic [WIDTH:0]    sum_s, shifted_s;
    logic              ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]  quo_s, rem_s;

    // Datapath helpers: operand magnitudes, one iteration step, sign fix-up
    always_comb begin
        s1_s      = ~op[0] & op1[WIDTH-1];
        s2_s      = ~op[0] & op2[WIDTH-1];
        mag1_s    = s1_s ? twos_w(op1) : op1;
        mag2_s    = s2_s ? twos_w(op2) : op2;
        sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shifted_s = {hi_q, lo_q[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, b_q});
        prod_s    = neg_lo_q ? twos_2w({hi_q, lo_q}) : {hi_q, lo_q};
        quo_s     = neg_lo_q ? twos_w(lo_q) : lo_q;
        rem_s     = neg_hi_q ? twos_w(hi_q) : hi_q;
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        b_d         = b_q;
        op_d        = op_q;
        tag_d       = tag_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        o_d         = o_q;
        tag_out_d   = tag_out_q;
        case (state_q)
            IDLE, DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (start) begin
                    op_d     = op;
                    tag_d    = tag_in;
                    cnt_d    = {CW{1'b0}};
                    neg_lo_d = s1_s ^ s2_s;
                    neg_hi_d = s1_s;
                    ovf_d    = (op == 2'b10) && (op1 == {1'b1, {(WIDTH-1){1'b0}}})
                               && (op2 == {WIDTH{1'b1}});
                    div0_d   = op[1] && (op2 == {WIDTH{1'b0}});
                    hi_d     = {WIDTH{1'b0}};
                    if (op[1] && (op2 == {WIDTH{1'b0}})) begin
                        // Divide-by-zero skips iteration; preload the fixed answer.
                        hi_d    = op1;
                        lo_d    = {WIDTH{1'b1}};
                        b_d     = op2;
                        state_d = FIX;
                    end else if (op[1]) begin
                        lo_d    = mag1_s;
                        b_d     = mag2_s;
                        state_d = ITER;
                    end else begin
                        lo_d    = mag2_s;
                        b_d     = mag1_s;
                        state_d = ITER;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[1]) begin
                        hi_d = ge_s ? (shifted_s[WIDTH-1:0] - b_q) : shifted_s[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], ge_s};
                    end else begin
                        hi_d = sum_s[WIDTH:1];
                        lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = FIX;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    tag_out_d = tag_q;
                    if (div0_q) begin
                        result_d    = lo_q;
                        remainder_d = hi_q;
                        o_d         = 1'b1;
                    end else if (op_q[1]) begin
                        result_d    = quo_s;
                        remainder_d = rem_s;
                        o_d         = ovf_q;
                    end else begin
                        result_d    = prod_s[WIDTH-1:0];
                        remainder_d = prod_s[2*WIDTH-1:WIDTH];
                        if (op_q[0]) begin
                            o_d = |prod_s[2*WIDTH-1:WIDTH];
                        end else begin
                            o_d = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
                        end
                    end
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            op_q        <= 2'b00;
            tag_q       <= {TAGW{1'b0}};
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            o_q         <= 1'b0;
            tag_out_q   <= {TAGW{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            o_q         <= o_d;
            tag_out_q   <= tag_out_d;
        end
    end

    assign busy      = (state_q == ITER) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign remainder = remainder_q;
    assign o         = o_q;
    assign tag_out   = tag_out_q;

endmodule
